// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 integer divider for DIV/DIVU.
//
// A request is accepted in IDLE. Signed operands are reduced to magnitudes
// at that point. One quotient bit is produced per cycle in ON. The final
// sign correction is applied as the result register is written, so the
// result is already valid during the END cycle that pulses ready.
// A zero divisor takes the short DIVZERO path and yields result = 0.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      division request, sampled only in IDLE
//   signed_div 1 = signed (DIV), 0 = unsigned (DIVU), sampled with start
//   opdata1    dividend, sampled with start
//   opdata2    divisor, sampled with start
//   annul      cancels a running operation, or blocks a request in IDLE
//   result     {remainder, quotient} -> {HI, LO}
//   ready      one-cycle pulse, result valid
//   busy       pipeline stall request
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic             accept;

  // Magnitude of a possibly signed operand; 0x80.. stays 0x80.. as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept = start && !annul;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = (opdata2 == '0) ? DIVZERO : ON;
      end
      DIVZERO: next_state = annul ? IDLE : END;
      ON: begin
        if (annul)             next_state = IDLE;
        else if (cnt == LAST)  next_state = END;
      end
      END:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy  = (state == IDLE && accept) || state == ON || state == DIVZERO;
  assign ready = (state == END);

  // One restoring step: the borrow out of the WIDTH+1 bit subtraction tells
  // whether the shifted partial remainder reaches the divisor.
  always_comb begin
    shifted   = {rem, dividend[WIDTH-1]};
    diff      = shifted - {1'b0, divisor};
    q_bit     = !diff[WIDTH];
    rem_next  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_next = {dividend[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dividend <= magnitude(opdata1, signed_div);
            divisor  <= magnitude(opdata2, signed_div);
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_r    <= signed_div && opdata1[WIDTH-1];
          end
        end
        ON: begin
          dividend <= quot_next;
          rem      <= rem_next;
          cnt      <= cnt + CNT_W'(1);
          // Result is written on the way into END so it is valid with ready.
          if (!annul && cnt == LAST)
            result <= {apply_sign(rem_next, neg_r), apply_sign(quot_next, neg_q)};
        end
        DIVZERO: begin
          if (!annul) result <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .result(result), .ready(ready), .busy(busy)
  );

  // Reference: plain language-level division. Signed division in SV truncates
  // toward zero with remainder taking the dividend's sign, as DIV requires.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a; sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issues one request in the current cycle and waits (bounded) for ready.
  // Returns the cycle offset of ready (-1 on timeout), the captured result and
  // the number of cycles busy was high. Leaves the bench at the start of the
  // cycle following END, so a back-to-back request may be issued directly.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] res, output int lat, output int bcyc);
    bcyc = 0; lat = -1; res = '0;
    start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
    @(negedge clk); if (busy) bcyc++;
    step(); start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (ready) begin lat = k; res = result; break; end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    #3;
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected %h", result, 64'd0); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    step(); step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_unsigned_basic();
    logic [63:0] res; int lat, bc;
    do_div(32'd100, 32'd7, 1'b0, res, lat, bc);
    checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_100_7: got %h expected %h", res, {32'd2, 32'd14}); end
    checks++; if (lat != 33) begin errors++; $display("FAIL udiv_latency: got %0d expected 33", lat); end
    checks++; if (bc != 33) begin errors++; $display("FAIL udiv_busy_cycles: got %0d expected 33", bc); end
  endtask

  task automatic test_signed();
    logic [63:0] res; int lat, bc;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, bc);
    checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL sdiv_m7_2: got %h expected %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    checks++; if (lat != 33) begin errors++; $display("FAIL sdiv_latency: got %0d expected 33", lat); end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, res, lat, bc);
    checks++; if (res !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL sdiv_7_m2: got %h expected %h", res, {32'd1, 32'hFFFF_FFFD}); end
  endtask

  task automatic test_div_zero();
    logic [63:0] res; int lat, bc;
    do_div(32'd5, 32'd0, 1'b0, res, lat, bc);
    checks++; if (res !== 64'd0) begin errors++; $display("FAIL divzero_result: got %h expected 0", res); end
    checks++; if (lat != 2) begin errors++; $display("FAIL divzero_latency: got %0d expected 2", lat); end
    checks++; if (bc != 2) begin errors++; $display("FAIL divzero_busy_cycles: got %0d expected 2", bc); end
  endtask

  task automatic test_boundaries();
    logic [63:0] res; int lat, bc;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, bc);
    checks++; if (res !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL sdiv_minint_m1: got %h expected %h", res, {32'd0, 32'h8000_0000}); end
    do_div(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, res, lat, bc);
    checks++; if (res !== {32'h0000_000F, 32'h0FFF_FFFF}) begin errors++; $display("FAIL udiv_max_16: got %h expected %h", res, {32'h0000_000F, 32'h0FFF_FFFF}); end
    do_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, res, lat, bc);
    checks++; if (res !== {32'hFFFF_FFFE, 32'd0}) begin errors++; $display("FAIL udiv_big_divisor: got %h expected %h", res, {32'hFFFF_FFFE, 32'd0}); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int lat, bc;
    do_div(32'd1000, 32'd10, 1'b1, res, lat, bc);
    checks++; if (res !== {32'd0, 32'd100}) begin errors++; $display("FAIL b2b_first: got %h expected %h", res, {32'd0, 32'd100}); end
    do_div(32'hFFFF_FFF0, 32'd3, 1'b1, res, lat, bc);
    checks++; if (res !== ref_div(32'hFFFF_FFF0, 32'd3, 1'b1)) begin errors++; $display("FAIL b2b_second: got %h expected %h", res, ref_div(32'hFFFF_FFF0, 32'd3, 1'b1)); end
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
    do_div(32'd9, 32'd0, 1'b1, res, lat, bc);
    do_div(32'd4, 32'd0, 1'b0, res, lat, bc);
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_divzero_latency: got %0d expected 2", lat); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_idle: got %b expected 0", ready); end
    step();
  endtask

  task automatic test_random();
    logic [63:0] res, exp; int lat, bc, exp_lat;
    logic [31:0] a, b; logic s;
    for (int i = 0; i < 60; i++) begin
      a = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      exp = ref_div(a, b, s);
      exp_lat = (b == 32'd0) ? 2 : 33;
      do_div(a, b, s, res, lat, bc);
      checks++; if (res !== exp) begin errors++; $display("FAIL random_result a=%h b=%h s=%b: got %h expected %h", a, b, s, res, exp); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL random_latency a=%h b=%h: got %0d expected %0d", a, b, lat, exp_lat); end
    end
  endtask

  task automatic test_annul();
    logic [63:0] res, r0; int lat, bc, pulses, busy_seen;
    do_div(32'd1000, 32'd3, 1'b0, r0, lat, bc);
    // annul during ON at T+10
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd5;
    step(); start = 1'b0;
    repeat (9) step();
    annul = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL annul_busy_on: got %b expected 1", busy); end
    step(); annul = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_busy_after: got %b expected 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL annul_ready_after: got %b expected 0", ready); end
    checks++; if (result !== r0) begin errors++; $display("FAIL annul_result_kept: got %h expected %h", result, r0); end
    step();
    do_div(32'd20, 32'd3, 1'b0, res, lat, bc);
    checks++; if (res !== {32'd2, 32'd6}) begin errors++; $display("FAIL annul_restart_result: got %h expected %h", res, {32'd2, 32'd6}); end
    checks++; if (lat != 33) begin errors++; $display("FAIL annul_restart_latency: got %0d expected 33", lat); end
    // annul together with start in IDLE, then annul in DIVZERO
    start = 1'b1; annul = 1'b1; opdata1 = 32'd8; opdata2 = 32'd2;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_idle_busy: got %b expected 0", busy); end
    step(); annul = 1'b0; opdata2 = 32'd0;
    step(); start = 1'b0; annul = 1'b1;
    step(); annul = 1'b0;
    pulses = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge clk); if (ready) pulses++; if (busy) busy_seen++;
      step();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL annul_no_ready: got %0d pulses expected 0", pulses); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL annul_no_busy: got %0d cycles expected 0", busy_seen); end
    checks++; if (result !== {32'd2, 32'd6}) begin errors++; $display("FAIL annul_divzero_result: got %h expected %h", result, {32'd2, 32'd6}); end
    // annul in END: ready still pulses with the new result
    start = 1'b1; opdata1 = 32'd12; opdata2 = 32'd4;
    step(); start = 1'b0;
    repeat (32) step();
    annul = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL annul_end_ready: got %b expected 1", ready); end
    checks++; if (result !== {32'd0, 32'd3}) begin errors++; $display("FAIL annul_end_result: got %h expected %h", result, {32'd0, 32'd3}); end
    step(); annul = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; int lat;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    step(); start = 1'b0;
    repeat (4) step();
    #2 resetn = 1'b0;
    #1;
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL midreset_result: got %h expected 0", result); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    step(); step();
    resetn = 1'b1;
    step();
    // start held high across the operation with changing operands
    start = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
    step(); opdata1 = 32'd999; opdata2 = 32'd1;
    lat = -1; res = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready) begin lat = k; res = result; start = 1'b0; break; end
      step();
    end
    start = 1'b0;
    checks++; if (res !== {32'd0, 32'd10}) begin errors++; $display("FAIL held_start_result: got %h expected %h", res, {32'd0, 32'd10}); end
    checks++; if (lat != 33) begin errors++; $display("FAIL held_start_latency: got %0d expected 33", lat); end
    step();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_start_idle_busy: got %b expected 0", busy); end
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_annul();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
